uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver: serial-in/parallel-out counterpart of the team's UART transmitter. It oversamples the line, detects start, samples data/parity/stop mid-bit and presents the frame as a parallel byte with status. Frame format (7/8 data bits, none/odd/even parity, 1/2 stop bits) uses the same configuration encoding as the TX side. It sits between the line pin and the host register interface, clocked by the system clock with a shared oversampling tick from the baud generator.

Parameters:
OVERSAMPLE, 16, sample ticks per bit period; power of 2, range 8..32.
SYNC_STAGES, 2, flip-flops in the serial-input synchronizer; minimum 2.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-low.
sample_tick  in  1  one-clk pulse, OVERSAMPLE pulses per bit period.
rx_in  in  1  serial line; idle high, LSB first.
parity_type  in  2  00/11 no parity, 01 odd, 10 even.
stop_bits  in  1  0 = 1 stop bit, 1 = 2 stop bits.
data_length  in  1  0 = 7 data bits, 1 = 8 data bits.
rx_data  out  8  received data; bit 7 forced to 0 in 7-bit mode.
rx_done  out  1  one-clk pulse when frame complete and outputs valid.
rx_active  out  1  high from start-bit detection until rx_done.
parity_error  out  1  parity check failed on last frame.
framing_error  out  1  a stop bit sampled low on last frame.

Behaviour:
- Reset (rst low, async): state IDLE; rx_data=0, rx_done=0, rx_active=0, parity_error=0, framing_error=0; synchronizer flops preset to 1; counters 0.
- rx_in passes through SYNC_STAGES flops; all logic uses the synchronized value rx_s.
- The tick counter and the bit counter advance only on clk edges where sample_tick=1.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: on sample_tick with rx_s=0 -> START, tick_cnt=0, rx_active=1. Latch parity_type/stop_bits/data_length into frame config; config changes mid-frame are ignored.
- START: at tick_cnt=OVERSAMPLE/2-1 re-sample. If rx_s=1 (glitch) -> IDLE, rx_active=0, no rx_done, flags unchanged. Otherwise -> DATA, tick_cnt=0, bit_cnt=0.
- DATA: sample rx_s at tick_cnt=OVERSAMPLE-1 (mid-bit) into shift register, LSB first. After 7 or 8 bits: -> PARITY if parity is enabled, else -> STOP.
- PARITY: sample mid-bit. Odd: XOR(data, pbit) must equal 1. Even: it must equal 0. Hold the result for the flag.
- STOP: sample each stop bit mid-bit. Any 0 sets the framing result. With 2 stop bits, both are checked. After the first stop bit is sampled low, the second is still sampled; there is no early abort.
- DONE: a single clk. Load rx_data, parity_error and framing_error from the frame results; rx_done=1 for exactly one clk; rx_active=0; -> IDLE.
- Latency: rx_done rises on the clk after the tick that samples the final stop bit mid-point.
- parity_error is 0 when parity is disabled. Flags and rx_data hold until the next DONE; they are not cleared by a new start.
- Back-to-back frames: IDLE start detection is possible in the clk after DONE, so a start edge immediately after the last stop mid-point is accepted.
- Line held low (break): frame completes with framing_error=1. The receiver then re-enters START on the next tick while the line stays low, and glitch-rejects only if the line has returned high.
- sample_tick and rst asserted simultaneously: reset wins.

Decomposition:
- Shared package uart_pkg: parity encodings PAR_NONE0=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE3=2'b11, and the rx state enum. Reuse the same encodings for the TX side.
- Sub-module uart_sync: SYNC_STAGES-deep synchronizer with async active-low reset to 1. The FSM, counters and shift register stay in uart_rx.

Test Plan:
- 8N1 (data_length=1, parity=00, stop=0), send 0xA5 -> rx_done one pulse ~9.5 bit times after start edge, rx_data=0xA5, both errors 0.
- 7O2 (data_length=0, parity=01, stop=1), send 7'h35 with parity bit 1 -> rx_data=0x35, parity_error=0, framing_error=0. Repeat with parity bit 0 -> parity_error=1.
- 8E1, send 0x3C with the stop bit driven 0 -> rx_data=0x3C, framing_error=1, parity_error=0.
- Low glitch of OVERSAMPLE/4 ticks on an idle line -> rx_active pulses then drops, no rx_done, rx_data and flags unchanged.
- Assert rst mid-DATA of a 0x5A frame -> all outputs 0 immediately. The next full frame 0xC3 after release -> rx_data=0xC3.
- Two back-to-back 8N1 frames 0x01, 0xFE with no idle gap -> two rx_done pulses, rx_data 0x01 then 0xFE.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART encodings, rx state type and frame config  | rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_DONE   = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic [1:0] parity;
    logic       two_stop;
    logic       eight_bits;
  } frame_cfg_t;

  function automatic logic parity_enabled(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// uart_sync : STAGES-deep input synchronizer, async active-low preset to 1 | rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : oversampling UART receiver, 7/8 data, N/O/E parity, 1/2 stop | rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       framing_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);

  logic rx_s;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  frame_cfg_t    cfg_q, cfg_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          rx_active_q, rx_active_d;
  logic          parity_error_q, parity_error_d;
  logic          framing_error_q, framing_error_d;
  logic [2:0]    last_bit;

  assign last_bit = cfg_q.eight_bits ? 3'd7 : 3'd6;

  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    cfg_d           = cfg_q;
    par_err_d       = par_err_q;
    frm_err_d       = frm_err_q;
    rx_data_d       = rx_data_q;
    rx_done_d       = 1'b0;
    rx_active_d     = rx_active_q;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;

    case (state_q)
      RX_IDLE: begin
        if (sample_tick && !rx_s) begin
          state_d     = RX_START;
          tick_cnt_d  = '0;
          rx_active_d = 1'b1;
          cfg_d       = '{parity: parity_type, two_stop: stop_bits, eight_bits: data_length};
          shift_d     = '0;
          par_err_d   = 1'b0;
          frm_err_d   = 1'b0;
        end
      end
      RX_START: begin
        if (sample_tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rx_s) begin
              state_d     = RX_IDLE;
              rx_active_d = 1'b0;
            end else begin
              state_d = RX_DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      RX_DATA: begin
        if (sample_tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d         = '0;
            shift_d[bit_cnt_q] = rx_s;
            if (bit_cnt_q == last_bit) begin
              bit_cnt_d = '0;
              state_d   = parity_enabled(cfg_q.parity) ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (sample_tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            // odd parity wants an overall XOR of 1, even wants 0
            par_err_d  = (^shift_q) ^ rx_s ^ (cfg_q.parity == PAR_ODD);
            state_d    = RX_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      RX_STOP: begin
        if (sample_tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              frm_err_d = 1'b1;
            end
            if (cfg_q.two_stop && (bit_cnt_q == 3'd0)) begin
              bit_cnt_d = 3'd1;
            end else begin
              state_d = RX_DONE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      RX_DONE: begin
        rx_data_d       = shift_q;
        parity_error_d  = par_err_q;
        framing_error_d = frm_err_q;
        rx_done_d       = 1'b1;
        rx_active_d     = 1'b0;
        state_d         = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= RX_IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      cfg_q           <= '0;
      par_err_q       <= 1'b0;
      frm_err_q       <= 1'b0;
      rx_data_q       <= '0;
      rx_done_q       <= 1'b0;
      rx_active_q     <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      cfg_q           <= cfg_d;
      par_err_q       <= par_err_d;
      frm_err_q       <= frm_err_d;
      rx_data_q       <= rx_data_d;
      rx_done_q       <= rx_done_d;
      rx_active_q     <= rx_active_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_done       = rx_done_q;
  assign rx_active     = rx_active_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;

endmodule

`default_nettype wire
